// File: rtl/img_crypt_pkg.sv
// Shared constants, FSM state type and PKCS#7 pad helper
// for the image block packer.
package img_crypt_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BYTE_W      = 8;
  localparam int BLOCK_W     = 128;

  typedef enum logic [1:0] {
    FILL,
    OUT,
    OUT_PAD
  } state_e;

  // Fill every byte after 'slot' with the PKCS#7 pad
  // value (number of padded bytes = 15 - slot).
  function automatic logic [BLOCK_W-1:0] pkcs7_pad(
    input logic [BLOCK_W-1:0] blk,
    input logic [3:0]         slot
  );
    logic [BLOCK_W-1:0] r;
    logic [BYTE_W-1:0]  fill;
    r    = blk;
    fill = BYTE_W'(BLOCK_BYTES - 1 - int'(slot));
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (i > int'(slot))
        r[BLOCK_W-1-BYTE_W*i -: BYTE_W] = fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/image_block_packer.sv
// Packs an image byte stream into 128-bit blocks, MSB first,
// with PKCS#7 padding on the final block.
// Ports: clk/rst (async, high); pix_* byte input with
// valid/ready/last; blk_* 128-bit block output with
// valid/ready/last.
module image_block_packer
  import img_crypt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTE_W-1:0]  pix_data,
  input  logic               pix_valid,
  input  logic               pix_last,
  output logic               pix_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_valid,
  output logic               blk_last,
  input  logic               blk_ready
);

  state_e             state_q;
  logic [3:0]         byte_cnt_q;
  logic               pad_pending_q;
  logic [BLOCK_W-1:0] blk_q;
  logic [BLOCK_W-1:0] blk_d;
  logic               valid_q;
  logic               last_q;
  logic               ready_q;
  logic               accept;
  logic               handshake;
  logic               at_end;

  assign accept    = pix_valid & ready_q;
  assign handshake = valid_q & blk_ready;
  assign at_end    = (byte_cnt_q == 4'd15);

  // Current byte dropped into its slot; padding applied
  // when the image ends before the block is full.
  always_comb begin
    blk_d = blk_q;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (byte_cnt_q == 4'(i))
        blk_d[BLOCK_W-1-BYTE_W*i -: BYTE_W] = pix_data;
    end
    if (pix_last && !at_end)
      blk_d = pkcs7_pad(blk_d, byte_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      byte_cnt_q    <= 4'd0;
      pad_pending_q <= 1'b0;
      blk_q         <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          ready_q <= 1'b1;
          if (accept) begin
            blk_q      <= blk_d;
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (pix_last || at_end) begin
              state_q       <= OUT;
              ready_q       <= 1'b0;
              valid_q       <= 1'b1;
              last_q        <= pix_last & ~at_end;
              pad_pending_q <= pix_last & at_end;
            end
          end
        end
        OUT: begin
          if (handshake) begin
            if (pad_pending_q) begin
              state_q <= OUT_PAD;
              blk_q   <= {BLOCK_BYTES{8'h10}};
              last_q  <= 1'b1;
            end else begin
              state_q    <= FILL;
              byte_cnt_q <= 4'd0;
              valid_q    <= 1'b0;
              last_q     <= 1'b0;
              ready_q    <= 1'b1;
            end
          end
        end
        OUT_PAD: begin
          if (handshake) begin
            state_q       <= FILL;
            byte_cnt_q    <= 4'd0;
            pad_pending_q <= 1'b0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            ready_q       <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign pix_ready = ready_q;
  assign blk_data  = blk_q;
  assign blk_valid = valid_q;
  assign blk_last  = last_q;

endmodule

// File: tb/tb_image_block_packer.sv
// Self-checking bench for image_block_packer with a
// block-level reference model built from the byte list.
module tb_image_block_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   pix_data = '0;
  logic         pix_valid = 1'b0;
  logic         pix_last = 1'b0;
  logic         pix_ready;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready = 1'b0;

  image_block_packer dut (
    .clk(clk), .rst(rst),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pix_ready),
    .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_last(blk_last), .blk_ready(blk_ready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]   img[$];
  logic [128:0] expq[$];
  logic [128:0] gotq[$];

  int cyc = 0;
  int last_acc_cyc = 0;
  int hs_cyc = 0;
  int pr_low = 0;
  logic acc;
  logic prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic prev_last;

  task automatic check(input string tag,
                       input logic [128:0] obs,
                       input logic [128:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Sample at negedge, then advance past the next posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    acc = pix_valid & pix_ready;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 129'(blk_valid), 129'(1));
        check("hold_data", {prev_last, prev_data},
              {blk_last, blk_data});
      end
      if (!pix_ready) pr_low++;
      if (acc && pix_last) last_acc_cyc = cyc;
      if (acc && !pix_last) last_acc_cyc = cyc;
      if (blk_valid && blk_ready) begin
        gotq.push_back({blk_last, blk_data});
        hs_cyc = cyc;
      end
      prev_stall = blk_valid & ~blk_ready;
      prev_data  = blk_data;
      prev_last  = blk_last;
    end
    @(posedge clk);
    #1;
  endtask

  // Expected blocks from the byte list: 16-byte groups,
  // then a PKCS#7 tail (or a full 0x10 block).
  task automatic build_model(input bit use_last);
    int n;
    int full;
    int rem;
    logic [127:0] d;
    n = img.size();
    full = n / 16;
    rem = n % 16;
    expq.delete();
    for (int b = 0; b < full; b++) begin
      d = '0;
      for (int i = 0; i < 16; i++)
        d = {d[119:0], img[b*16+i]};
      expq.push_back({1'b0, d});
    end
    if (use_last) begin
      if (rem == 0) begin
        expq.push_back({1'b1, {16{8'h10}}});
      end else begin
        d = '0;
        for (int i = 0; i < 16; i++) begin
          if (i < rem) d = {d[119:0], img[full*16+i]};
          else d = {d[119:0], 8'(16 - rem)};
        end
        expq.push_back({1'b1, d});
      end
    end
  endtask

  task automatic run_image(input string tag,
                           input bit use_last,
                           input int gap_pct,
                           input int stall_pct);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    gotq.delete();
    build_model(use_last);
    while (gotq.size() < expq.size() && guard < 4000) begin
      guard++;
      if (idx < img.size()) begin
        pix_valid = ($urandom_range(0, 99) >= gap_pct);
      end else begin
        pix_valid = 1'b0;
      end
      if (pix_valid) begin
        pix_data = img[idx];
        pix_last = use_last && (idx == img.size() - 1);
      end else begin
        pix_data = 8'($urandom);
        pix_last = 1'($urandom);
      end
      blk_ready = ($urandom_range(0, 99) >= stall_pct);
      tick();
      if (acc) idx++;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    blk_ready = 1'b0;
    check({tag, "_nblk"}, 129'(gotq.size()),
          129'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < gotq.size())
        check($sformatf("%s_blk%0d", tag, i), gotq[i],
              expq[i]);
    end
    tick();
    check({tag, "_fill_ready"}, 129'(pix_ready), 129'(1));
    check({tag, "_fill_valid"}, 129'(blk_valid), 129'(0));
  endtask

  initial begin
    logic [127:0] cap;
    int idx;
    int guard;

    // Reset values
    #2;
    check("rst_ready", 129'(pix_ready), 129'(0));
    check("rst_valid", 129'(blk_valid), 129'(0));
    check("rst_last", 129'(blk_last), 129'(0));
    check("rst_data", 129'(blk_data), 129'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check("ready_pre_edge", 129'(pix_ready), 129'(0));
    @(posedge clk); #1;
    check("ready_after_rst", 129'(pix_ready), 129'(1));

    // Sixteen bytes 00..0F, no last
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'(i));
    pr_low = 0;
    run_image("seq16", 1'b0, 0, 0);
    check("seq16_latency", 129'(hs_cyc - last_acc_cyc),
          129'(1));
    check("seq16_ready_low", 129'(pr_low), 129'(1));

    // Short image with pad 0x0D
    img.delete();
    img.push_back(8'hAA);
    img.push_back(8'hBB);
    img.push_back(8'hCC);
    run_image("abc", 1'b1, 0, 0);
    check("abc_literal", 129'(gotq[0]),
          {1'b1, 24'hAABBCC, {13{8'h0D}}});

    // Exactly 16 bytes with last: extra full pad block
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    run_image("full_last", 1'b1, 0, 0);

    // Stall in OUT for 10 cycles with pix_valid held
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    build_model(1'b0);
    gotq.delete();
    idx = 0;
    guard = 0;
    blk_ready = 1'b0;
    while (idx < 16 && guard < 200) begin
      guard++;
      pix_valid = 1'b1;
      pix_data = img[idx];
      pix_last = 1'b0;
      tick();
      if (acc) idx++;
    end
    check("stall_fed", 129'(idx), 129'(16));
    cap = expq[0][127:0];
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1;
      pix_data = 8'($urandom);
      pix_last = 1'($urandom);
      tick();
      check("stall_ready", 129'(pix_ready), 129'(0));
      check("stall_noacc", 129'(acc), 129'(0));
      check("stall_data", 129'(blk_data), 129'(cap));
    end
    pix_valid = 1'b0;
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    check("stall_nblk", 129'(gotq.size()), 129'(1));
    if (gotq.size() > 0)
      check("stall_blk", gotq[0], expq[0]);

    // Reset after 7 bytes, then 16 fresh bytes
    gotq.delete();
    idx = 0;
    guard = 0;
    blk_ready = 1'b1;
    while (idx < 7 && guard < 100) begin
      guard++;
      pix_valid = 1'b1;
      pix_data = 8'($urandom);
      pix_last = 1'b0;
      tick();
      if (acc) idx++;
    end
    pix_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_valid", 129'(blk_valid), 129'(0));
      check("mid_rst_ready", 129'(pix_ready), 129'(0));
    end
    check("mid_rst_data", 129'(blk_data), 129'(0));
    rst = 1'b0;
    tick();
    check("mid_rst_noout", 129'(gotq.size()), 129'(0));
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    run_image("fresh16", 1'b0, 0, 0);

    // 40 bytes with gaps and back-pressure
    img.delete();
    for (int i = 0; i < 40; i++) img.push_back(8'($urandom));
    run_image("img40", 1'b1, 40, 30);

    // Random images
    for (int k = 0; k < 6; k++) begin
      img.delete();
      for (int i = 0; i < $urandom_range(1, 50); i++)
        img.push_back(8'($urandom));
      run_image($sformatf("rnd%0d", k), 1'b1, 25, 25);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
